alu_share_arbiter: RTL and testbench

// - Shares one ALU (add/sub/and/or/slt, 3-bit alu_control, N/Z/C/V flags) between NUM_REQ requesters.
// - Round-robin arbitration; valid/ready request and response handshakes.
// - Registered operand launch and registered result capture.
// - Sits between issue sources (e.g. address-gen, branch-compare, debug unit) and a single ALU instance.
// - Rejects illegal opcodes so the ALU never produces X results.

---
 rtl/alu_share_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets NUM_REQ issue sources
// share a single ALU. It accepts one operation at a time, launches registered
// operands to the ALU, captures the result, and returns it over a valid/ready
// response handshake. Illegal opcodes never reach the ALU. They come back as
// an error response with the result and flags zeroed.
module alu_share_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_src_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_src_b,
   input  logic [NUM_REQ*3-1:0]          req_op,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   output logic [3:0]                    rsp_flags,
   output logic                          rsp_err,
   output logic [DATA_WIDTH-1:0]         alu_src_a,
   output logic [DATA_WIDTH-1:0]         alu_src_b,
   output logic [2:0]                    alu_control,
   input  logic [DATA_WIDTH-1:0]         alu_result,
   input  logic [3:0]                    alu_flags
);

   localparam int                 PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W:0]     LP_NREQ = (PTR_W+1)'(NUM_REQ);
   localparam logic [NUM_REQ-1:0] LP_ONE  = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   logic [PTR_W-1:0]        r_ptr;
   logic [PTR_W-1:0]        r_grant;
   logic                    r_illegal;
   logic [DATA_WIDTH-1:0]   r_alu_a;
   logic [DATA_WIDTH-1:0]   r_alu_b;
   logic [2:0]              r_alu_ctrl;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_result;
   logic [3:0]              r_rsp_flags;
   logic                    r_rsp_err;

   logic                    w_found;
   logic [PTR_W-1:0]        w_gidx;
   logic [PTR_W:0]          w_sum;
   logic [PTR_W-1:0]        w_cand;
   logic [DATA_WIDTH-1:0]   w_sel_a;
   logic [DATA_WIDTH-1:0]   w_sel_b;
   logic [2:0]              w_sel_op;
   logic [NUM_REQ-1:0]      w_grant_oh;

   // Reduce a pointer sum (at most 2*NUM_REQ-2) back into 0..NUM_REQ-1.
   function automatic logic [PTR_W-1:0] f_wrap(input logic [PTR_W:0] v);
      logic [PTR_W:0] t;
      t = (v >= LP_NREQ) ? (v - LP_NREQ) : v;
      return t[PTR_W-1:0];
   endfunction

   // add, sub, and, or, slt are the only codes the ALU implements.
   function automatic logic f_legal(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010, 3'b011, 3'b101: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   // Round-robin pick: first valid requester starting at the priority pointer.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum  = {1'b0, r_ptr} + (PTR_W+1)'(k);
         w_cand = f_wrap(w_sum);
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
   end

   // Operand/opcode mux for the winning requester.
   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_gidx == PTR_W'(k)) begin
            w_sel_a  = req_src_a[k*DATA_WIDTH +: DATA_WIDTH];
            w_sel_b  = req_src_b[k*DATA_WIDTH +: DATA_WIDTH];
            w_sel_op = req_op[k*3 +: 3];
         end
      end
   end

   // Accept strobe: one-hot, only while idle. Held low during reset so every
   // output reads 0 while rst is asserted.
   always_comb begin
      req_ready = '0;
      if (!rst && r_state == S_IDLE && w_found) begin
         req_ready[w_gidx] = 1'b1;
      end
   end

   assign w_grant_oh = LP_ONE << r_grant;

   // Control FSM with registered ALU launch and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_grant      <= '0;
         r_illegal    <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_ctrl   <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant    <= w_gidx;
                  r_alu_a    <= w_sel_a;
                  r_alu_b    <= w_sel_b;
                  r_alu_ctrl <= f_legal(w_sel_op) ? w_sel_op : 3'b000;
                  r_illegal  <= !f_legal(w_sel_op);
                  r_state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_rsp_result <= r_illegal ? '0   : alu_result;
               r_rsp_flags  <= r_illegal ? 4'h0 : alu_flags;
               r_rsp_err    <= r_illegal;
               r_rsp_valid  <= w_grant_oh;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready[r_grant]) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= f_wrap({1'b0, r_grant} + (PTR_W+1)'(1));
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_src_a   = r_alu_a;
   assign alu_src_b   = r_alu_b;
   assign alu_control = r_alu_ctrl;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_result  = r_rsp_result;
   assign rsp_flags   = r_rsp_flags;
   assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a
// behavioural 32-bit ALU (flags {N,Z,C,V}) attached to the ALU-side ports.
module tb_alu_share_arbiter;

   localparam int W = 32;
   localparam int N = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_src_a;
   logic [N*W-1:0] req_src_b;
   logic [N*3-1:0] req_op;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [W-1:0]   rsp_result;
   logic [3:0]     rsp_flags;
   logic           rsp_err;
   logic [W-1:0]   alu_src_a;
   logic [W-1:0]   alu_src_b;
   logic [2:0]     alu_control;
   logic [W-1:0]   alu_result;
   logic [3:0]     alu_flags;
   logic [W:0]     t33;

   int n_checks = 0;
   int n_errors = 0;

   alu_share_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_src_a   (req_src_a),
      .req_src_b   (req_src_b),
      .req_op      (req_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags),
      .rsp_err     (rsp_err),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU; unimplemented codes return junk so leaks are visible.
   always_comb begin
      alu_result = 32'hDEAD_BEEF;
      alu_flags  = 4'hF;
      t33        = '0;
      case (alu_control)
         3'b000: begin
            t33        = {1'b0, alu_src_a} + {1'b0, alu_src_b};
            alu_result = t33[W-1:0];
            alu_flags  = {t33[W-1], t33[W-1:0] == '0, t33[W],
                          (alu_src_a[W-1] == alu_src_b[W-1]) && (t33[W-1] != alu_src_a[W-1])};
         end
         3'b001: begin
            t33        = {1'b0, alu_src_a} + {1'b0, ~alu_src_b} + 33'd1;
            alu_result = t33[W-1:0];
            alu_flags  = {t33[W-1], t33[W-1:0] == '0, t33[W],
                          (alu_src_a[W-1] != alu_src_b[W-1]) && (t33[W-1] != alu_src_a[W-1])};
         end
         3'b010: begin
            alu_result = alu_src_a & alu_src_b;
            alu_flags  = {alu_result[W-1], alu_result == '0, 2'b00};
         end
         3'b011: begin
            alu_result = alu_src_a | alu_src_b;
            alu_flags  = {alu_result[W-1], alu_result == '0, 2'b00};
         end
         3'b101: begin
            alu_result = ($signed(alu_src_a) < $signed(alu_src_b)) ? 32'd1 : 32'd0;
            alu_flags  = {alu_result[W-1], alu_result == '0, 2'b00};
         end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
      req_src_a[idx*W +: W] = a;
      req_src_b[idx*W +: W] = b;
      req_op[idx*3 +: 3]    = op;
   endtask

   // One complete transaction from a single requester; starts and ends at a negedge in IDLE.
   task automatic run_op(input string tag, input int idx, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flg,
                         input logic exp_err, input logic [2:0] exp_ctrl);
      logic [N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      set_req(idx, a, b, op);
      req_valid = oh;
      rsp_ready = '1;
      #1;
      chk({tag, ".req_ready"}, 64'(req_ready), 64'(oh));
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk({tag, ".alu_a"}, 64'(alu_src_a), 64'(a));
      chk({tag, ".alu_b"}, 64'(alu_src_b), 64'(b));
      chk({tag, ".alu_ctrl"}, 64'(alu_control), 64'(exp_ctrl));
      chk({tag, ".exec_rsp_valid"}, 64'(rsp_valid), 64'(0));
      @(negedge clk);
      chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(oh));
      chk({tag, ".result"}, 64'(rsp_result), 64'(exp_res));
      chk({tag, ".flags"}, 64'(rsp_flags), 64'(exp_flg));
      chk({tag, ".err"}, 64'(rsp_err), 64'(exp_err));
      @(negedge clk);
      chk({tag, ".rsp_valid_drop"}, 64'(rsp_valid), 64'(0));
      chk({tag, ".result_hold"}, 64'(rsp_result), 64'(exp_res));
      chk({tag, ".alu_a_hold"}, 64'(alu_src_a), 64'(a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] grants [4];
      logic [N-1:0] rvs    [4];
      logic [W-1:0] ress   [4];
      int           ng;
      int           nr;

      rst       = 1'b1;
      req_valid = '0;
      req_src_a = '0;
      req_src_b = '0;
      req_op    = '0;
      rsp_ready = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.req_ready", 64'(req_ready), 64'(0));
      chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst.result", 64'(rsp_result), 64'(0));
      chk("rst.flags", 64'(rsp_flags), 64'(0));
      chk("rst.err", 64'(rsp_err), 64'(0));
      chk("rst.alu_a", 64'(alu_src_a), 64'(0));
      chk("rst.alu_ctrl", 64'(alu_control), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // ptr sequence: 0 -> 1 -> 0 -> 0 -> 1 -> 0 -> 1 -> 0
      run_op("add",     0, 32'd5, 32'd7, 3'b000, 32'd12, 4'b0000, 1'b0, 3'b000);
      run_op("sub_ovf", 1, 32'h8000_0000, 32'd1, 3'b001, 32'h7FFF_FFFF, 4'b0011, 1'b0, 3'b001);
      run_op("slt_r1",  1, 32'hFFFF_FFFF, 32'd0, 3'b101, 32'd1, 4'b0000, 1'b0, 3'b101);
      run_op("sub_z",   0, 32'd3, 32'd3, 3'b001, 32'd0, 4'b0110, 1'b0, 3'b001);
      run_op("and",     1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 4'b1000, 1'b0, 3'b010);
      run_op("or",      0, 32'h0000_00F0, 32'h0000_000F, 3'b011, 32'h0000_00FF, 4'b0000, 1'b0, 3'b011);
      run_op("illegal", 1, 32'd5, 32'd7, 3'b110, 32'd0, 4'b0000, 1'b1, 3'b000);

      // Round-robin with both requesters continuously valid.
      set_req(0, 32'd1, 32'd1, 3'b000);
      set_req(1, 32'd10, 32'd20, 3'b000);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      ng = 0;
      nr = 0;
      for (int c = 0; c < 40 && nr < 4; c++) begin
         #1;
         if (req_ready != '0 && ng < 4) begin
            grants[ng] = req_ready;
            ng++;
         end
         if (rsp_valid != '0) begin
            rvs[nr]  = rsp_valid;
            ress[nr] = rsp_result;
            nr++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      chk("rr.responses", 64'(nr), 64'(4));
      chk("rr.grants", 64'(ng), 64'(4));
      if (nr == 4 && ng == 4) begin
         chk("rr.grant0", 64'(grants[0]), 64'(2'b01));
         chk("rr.grant1", 64'(grants[1]), 64'(2'b10));
         chk("rr.grant2", 64'(grants[2]), 64'(2'b01));
         chk("rr.grant3", 64'(grants[3]), 64'(2'b10));
         chk("rr.rsp0", 64'({rvs[0], ress[0]}), {30'd0, 2'b01, 32'd2});
         chk("rr.rsp1", 64'({rvs[1], ress[1]}), {30'd0, 2'b10, 32'd30});
         chk("rr.rsp3", 64'({rvs[3], ress[3]}), {30'd0, 2'b10, 32'd30});
      end

      // Backpressure: response held, non-granted rsp_ready ignored, no new grant.
      set_req(0, 32'd100, 32'd23, 3'b000);
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      #1;
      chk("bp.req_ready", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      #1 req_valid = 2'b10;
      @(negedge clk);
      chk("bp.exec_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      rsp_ready = 2'b10;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp.hold_valid", 64'(rsp_valid), 64'(2'b01));
         chk("bp.hold_result", 64'(rsp_result), 64'(123));
         chk("bp.hold_no_grant", 64'(req_ready), 64'(0));
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      chk("bp.released", 64'(rsp_valid), 64'(0));
      chk("bp.next_grant_r1", 64'(req_ready), 64'(2'b10));
      req_valid = '0;
      rsp_ready = 2'b11;

      // Reset during EXEC, then req0 wins after release.
      set_req(1, 32'd4, 32'd4, 3'b000);
      req_valid = 2'b10;
      #1;
      chk("mrst.accept", 64'(req_ready), 64'(2'b10));
      @(posedge clk);
      #1 req_valid = '0;
      #1 rst = 1'b1;
      #1;
      chk("mrst.alu_a", 64'(alu_src_a), 64'(0));
      chk("mrst.alu_b", 64'(alu_src_b), 64'(0));
      chk("mrst.result", 64'(rsp_result), 64'(0));
      chk("mrst.rsp_valid", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 32'd1, 32'd1, 3'b000);
      req_valid = 2'b11;
      #1;
      chk("mrst.req0_wins", 64'(req_ready), 64'(2'b01));
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("mrst.no_stale_rsp", 64'(rsp_valid), 64'(0));
      @(negedge clk);
      chk("mrst.rsp", 64'({rsp_valid, rsp_result}), {30'd0, 2'b01, 32'd2});
      @(negedge clk);
      chk("mrst.done", 64'(rsp_valid), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
